// File: rtl/ksa_engine.sv
// ksa_engine: RC4-style key-scheduling engine driving an external
// synchronous state memory (one read latency cycle). The engine first fills
// the memory with the identity permutation, then performs the keyed swap
// pass one location at a time and pulses fin_strobe when the pass ends.
module ksa_engine #(
  parameter int ADDR_W    = 8,
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [ADDR_W-1:0]      address,
  output logic [7:0]             data,
  output logic                   wr_en,
  input  logic [7:0]             mem_q,
  output logic                   task_on,
  output logic                   fin_strobe
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int KI_W  = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [ADDR_W-1:0] I_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [KI_W-1:0]   KI_LAST = KI_W'(KEY_BYTES - 1);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_INIT = 4'd1,
    S_RDI  = 4'd2,
    S_LDI  = 4'd3,
    S_RDJ  = 4'd4,
    S_LDJ  = 4'd5,
    S_WRI  = 4'd6,
    S_WRJ  = 4'd7,
    S_DONE = 4'd8
  } state_t;

  state_t                 state_q;
  logic [ADDR_W-1:0]      i_q;
  logic [ADDR_W-1:0]      j_q;
  logic [KI_W-1:0]        kidx_q;     // tracks i mod KEY_BYTES without a divider
  logic [8*KEY_BYTES-1:0] key_q;
  logic [7:0]             si_q;
  logic [ADDR_W-1:0]      address_q;
  logic [7:0]             data_q;     // also serves as the sj holding register
  logic                   wr_en_q;
  logic                   task_on_q;
  logic                   fin_q;

  logic [7:0]             key_byte_s;
  logic [ADDR_W-1:0]      i_inc_s;
  logic [ADDR_W-1:0]      j_d;

  // Select key byte kidx_q (byte 0 is the most significant byte) as an AND-OR mux.
  always_comb begin
    key_byte_s = 8'h00;
    for (int b = 0; b < KEY_BYTES; b++) begin
      key_byte_s = key_byte_s |
                   (key_q[8*(KEY_BYTES-1-b) +: 8] & {8{kidx_q == KI_W'(b)}});
    end
  end

  // Next i and next j; the cast truncation implements the mod-DEPTH wrap.
  always_comb begin
    i_inc_s = i_q + ADDR_W'(1);
    j_d     = ADDR_W'(8'(j_q) + mem_q + key_byte_s);
  end

  // Control FSM; every output is a register loaded on entry to its state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      i_q       <= '0;
      j_q       <= '0;
      kidx_q    <= '0;
      key_q     <= '0;
      si_q      <= 8'h00;
      address_q <= '0;
      data_q    <= 8'h00;
      wr_en_q   <= 1'b0;
      task_on_q <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            key_q     <= key;
            i_q       <= '0;
            j_q       <= '0;
            kidx_q    <= '0;
            address_q <= '0;
            data_q    <= 8'h00;
            wr_en_q   <= 1'b1;
            task_on_q <= 1'b1;
            state_q   <= S_INIT;
          end else begin
            wr_en_q   <= 1'b0;
            task_on_q <= 1'b0;
            fin_q     <= 1'b0;
          end
        end
        S_INIT: begin
          if (i_q == I_LAST) begin
            i_q       <= '0;
            address_q <= '0;
            wr_en_q   <= 1'b0;
            state_q   <= S_RDI;
          end else begin
            i_q       <= i_inc_s;
            address_q <= i_inc_s;
            data_q    <= 8'(i_inc_s);
          end
        end
        S_RDI: begin
          state_q <= S_LDI;
        end
        S_LDI: begin
          // mem_q now holds S[i]; j moves and the read of S[j] is issued.
          si_q      <= mem_q;
          j_q       <= j_d;
          address_q <= j_d;
          state_q   <= S_RDJ;
        end
        S_RDJ: begin
          state_q <= S_LDJ;
        end
        S_LDJ: begin
          address_q <= i_q;
          data_q    <= mem_q;
          wr_en_q   <= 1'b1;
          state_q   <= S_WRI;
        end
        S_WRI: begin
          address_q <= j_q;
          data_q    <= si_q;
          state_q   <= S_WRJ;
        end
        S_WRJ: begin
          wr_en_q <= 1'b0;
          if (i_q == I_LAST) begin
            fin_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            i_q       <= i_inc_s;
            address_q <= i_inc_s;
            kidx_q    <= (kidx_q == KI_LAST) ? '0 : kidx_q + KI_W'(1);
            state_q   <= S_RDI;
          end
        end
        S_DONE: begin
          fin_q     <= 1'b0;
          task_on_q <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: begin
          wr_en_q   <= 1'b0;
          task_on_q <= 1'b0;
          fin_q     <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign address    = address_q;
  assign data       = data_q;
  assign wr_en      = wr_en_q;
  assign task_on    = task_on_q;
  assign fin_strobe = fin_q;

endmodule

// File: tb/tb_ksa_engine.sv
// Testbench for ksa_engine: three instances (4-entry/1-byte key, defaults,
// 5-byte key), each with a behavioural synchronous memory, checked against
// a plain software RC4 key-schedule model.
module tb_ksa_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]   rst_v;
  logic [2:0]   start_v;
  logic [255:0] key_bus;
  wire  [1:0]   addr_small;
  wire  [7:0]   addr_w [3];
  wire  [7:0]   data_w [3];
  wire  [2:0]   wr_en_v;
  wire  [2:0]   task_on_v;
  wire  [2:0]   fin_v;
  logic [7:0]   mem_q_r [3];
  logic [7:0]   mem_v [3][256];
  logic [2:0]   fin_prev = 3'b000;

  int total = 0;
  int bad   = 0;
  int viol  = 0;
  int exp_s [256];

  assign addr_w[0] = {6'd0, addr_small};

  ksa_engine #(.ADDR_W(2), .KEY_BYTES(1)) u_small (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .key(key_bus[7:0]),
    .address(addr_small), .data(data_w[0]), .wr_en(wr_en_v[0]),
    .mem_q(mem_q_r[0]), .task_on(task_on_v[0]), .fin_strobe(fin_v[0]));

  ksa_engine #(.ADDR_W(8), .KEY_BYTES(3)) u_dflt (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .key(key_bus[23:0]),
    .address(addr_w[1]), .data(data_w[1]), .wr_en(wr_en_v[1]),
    .mem_q(mem_q_r[1]), .task_on(task_on_v[1]), .fin_strobe(fin_v[1]));

  ksa_engine #(.ADDR_W(8), .KEY_BYTES(5)) u_k5 (
    .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .key(key_bus[39:0]),
    .address(addr_w[2]), .data(data_w[2]), .wr_en(wr_en_v[2]),
    .mem_q(mem_q_r[2]), .task_on(task_on_v[2]), .fin_strobe(fin_v[2]));

  // Synchronous state memories: read data appears one edge after the address.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (wr_en_v[k] === 1'b1) mem_v[k][addr_w[k]] <= data_w[k];
      mem_q_r[k] <= mem_v[k][addr_w[k]];
    end
  end

  // Per-cycle protocol monitor: fin never two cycles running, writes only while busy.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (fin_v[k] === 1'b1 && fin_prev[k] === 1'b1) viol++;
      if (wr_en_v[k] === 1'b1 && task_on_v[k] !== 1'b1) viol++;
      if (fin_v[k] === 1'b1 && (wr_en_v[k] !== 1'b0 || task_on_v[k] !== 1'b1)) viol++;
    end
    fin_prev = fin_v;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Software RC4 key schedule over a DEPTH-entry table and kb-byte key.
  task automatic ksa_model(input int depth, input int kb, input logic [255:0] keyv);
    int j, t, kbyte;
    for (int k = 0; k < depth; k++) exp_s[k] = k;
    j = 0;
    for (int i = 0; i < depth; i++) begin
      kbyte = int'(keyv[8*(kb-1-(i % kb)) +: 8]);
      j = (j + exp_s[i] + kbyte) % depth;
      t = exp_s[i]; exp_s[i] = exp_s[j]; exp_s[j] = t;
    end
  endtask

  task automatic wait_idle(input int w);
    int g = 0;
    @(negedge clk);
    while (task_on_v[w] !== 1'b0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) chk_eq("idle_timeout", g, 0);
  endtask

  // One full run: latency, write count, busy flag, end-of-run, final table.
  task automatic do_run(input int w, input int depth, input int kb,
                        input logic [255:0] keyv, input int mid_start, input string tag);
    int fin_at = -1;
    int wrs = 0;
    int ton_bad = 0;
    int lim = 7 * depth + 20;
    wait_idle(w);
    key_bus = keyv;
    start_v[w] = 1'b1;
    @(posedge clk); #1;
    start_v[w] = 1'b0;
    key_bus = rand_key();
    for (int n = 0; n <= lim; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      start_v[w] = (n == mid_start);
      if (fin_v[w] === 1'b1) begin
        fin_at = n;
        break;
      end
      if (wr_en_v[w] === 1'b1) wrs++;
      if (task_on_v[w] !== 1'b1) ton_bad++;
    end
    start_v[w] = 1'b0;
    chk_eq({tag, "_latency"}, fin_at, 7 * depth);
    chk_eq({tag, "_writes"}, wrs, 3 * depth);
    chk_eq({tag, "_busy"}, ton_bad, 0);
    @(posedge clk); #1;
    chk_eq({tag, "_fin_off"}, fin_v[w], 0);
    chk_eq({tag, "_idle"}, task_on_v[w], 0);
    ksa_model(depth, kb, keyv);
    for (int k = 0; k < depth; k++)
      chk_eq($sformatf("%s_mem%0d", tag, k), mem_v[w][k], exp_s[k]);
  endtask

  task automatic reset_test();
    int idle_bad = 0;
    wait_idle(1);
    key_bus = rand_key();
    start_v[1] = 1'b1;
    @(posedge clk); #1;
    start_v[1] = 1'b0;
    repeat (560) @(posedge clk);
    #1;
    chk_eq("rst_wri_we", wr_en_v[1], 1);
    chk_eq("rst_wri_addr", addr_w[1], 50);
    rst_v[1] = 1'b0;
    start_v[1] = 1'b1;
    @(posedge clk); #1;
    chk_eq("rst_addr", addr_w[1], 0);
    chk_eq("rst_data", data_w[1], 0);
    chk_eq("rst_we", wr_en_v[1], 0);
    chk_eq("rst_task_on", task_on_v[1], 0);
    chk_eq("rst_fin", fin_v[1], 0);
    rst_v[1] = 1'b1;
    start_v[1] = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (task_on_v[1] !== 1'b0 || wr_en_v[1] !== 1'b0) idle_bad++;
    end
    chk_eq("rst_stays_idle", idle_bad, 0);
  endtask

  initial begin
    int ref4 [4];
    ref4 = '{0, 2, 3, 1};
    rst_v   = 3'b000;
    start_v = 3'b111;
    key_bus = rand_key();
    repeat (3) @(posedge clk);
    #1;
    for (int w = 0; w < 3; w++) begin
      chk_eq($sformatf("reset%0d_addr", w), addr_w[w], 0);
      chk_eq($sformatf("reset%0d_data", w), data_w[w], 0);
      chk_eq($sformatf("reset%0d_we", w), wr_en_v[w], 0);
      chk_eq($sformatf("reset%0d_task_on", w), task_on_v[w], 0);
      chk_eq($sformatf("reset%0d_fin", w), fin_v[w], 0);
    end
    @(negedge clk);
    rst_v   = 3'b111;
    start_v = 3'b000;

    do_run(0, 4, 1, 256'h0, -1, "small_k0");
    for (int k = 0; k < 4; k++)
      chk_eq($sformatf("small_k0_fixed%0d", k), mem_v[0][k], ref4[k]);
    for (int r = 0; r < 3; r++) do_run(0, 4, 1, rand_key(), -1, "small_rnd");

    do_run(1, 256, 3, 256'h000249, -1, "dflt_249");
    do_run(1, 256, 3, rand_key(), 100, "dflt_mid");
    reset_test();
    do_run(1, 256, 3, 256'h000249, -1, "dflt_rst249");
    do_run(1, 256, 3, rand_key(), -1, "dflt_rnd");

    do_run(2, 256, 5, 256'h0102030405, -1, "k5_fixed");
    do_run(2, 256, 5, rand_key(), -1, "k5_rnd");

    @(negedge clk);
    chk_eq("monitor", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ksa_engine.md
KSA_ENGINE -- requirements
Module: ksa_engine

Interface
REQ-001 Parameter ADDR_W, default 8: state-memory address width; DEPTH = 2**ADDR_W; legal range 2..8.
REQ-002 Parameter KEY_BYTES, default 3: key length in bytes; legal range 1..32.
REQ-003 Port clk  input  1: single clock; all state changes on rising edge.
REQ-004 Port rst  input  1: reset, synchronous, active-low.
REQ-005 Port start  input  1: begin a run; sampled only in IDLE.
REQ-006 Port key  input  8*KEY_BYTES: secret key; key byte 0 = key[8*KEY_BYTES-1 -: 8] (MSB-first).
REQ-007 Port address  output  ADDR_W: state-memory address.
REQ-008 Port data  output  8: state-memory write data.
REQ-009 Port wr_en  output  1: state-memory write enable.
REQ-010 Port mem_q  input  8: state-memory read data, valid on the edge after the edge that sampled address.
REQ-011 Port task_on  output  1: high in every state except IDLE.
REQ-012 Port fin_strobe  output  1: one-cycle completion pulse.

Function
REQ-013 States: IDLE, INIT, RDI, LDI, RDJ, LDJ, WRI, WRJ, DONE.
REQ-014 IDLE with start=1: key latched, i=0, j=0, next state INIT; start=0: stay IDLE.
REQ-015 INIT: address=i, data=i zero-extended to 8 bits, wr_en=1; i increments each cycle; after i=DEPTH-1, i wraps to 0 and next state is RDI.
REQ-016 RDI: address=i, wr_en=0.
REQ-017 LDI: si captured from mem_q; j <= (j + si + key[i mod KEY_BYTES]) mod DEPTH.
REQ-018 RDJ: address=j (updated), wr_en=0.
REQ-019 LDJ: sj captured from mem_q.
REQ-020 WRI: address=i, data=sj, wr_en=1.
REQ-021 WRJ: address=j, data=si, wr_en=1; if i=DEPTH-1 next state DONE, else i+1 and RDI.
REQ-022 i=j: both writes performed; location keeps its value.
REQ-023 Key index i mod KEY_BYTES wraps per KEY_BYTES, independent of DEPTH.
REQ-024 DONE: fin_strobe=1 for exactly one cycle, wr_en=0; next state IDLE.
REQ-025 Latency: fin_strobe high during the cycle beginning 7*DEPTH rising edges after the edge that sampled start (1792 for DEPTH=256).
REQ-026 start ignored outside IDLE; key changes after the start-sampling edge have no effect.
REQ-027 start high in IDLE on the edge after DONE begins a new run.
REQ-028 wr_en=0 in IDLE, RDI, LDI, RDJ, LDJ, DONE.

Reset
REQ-029 rst=0 on a rising edge: state IDLE; i, j, si, sj = 0; address=0, data=0, wr_en=0, task_on=0, fin_strobe=0.
REQ-030 Reset mid-run aborts with no further writes; memory contents are undefined until a new run completes.
REQ-031 start is ignored on any edge where rst=0.

Verification
REQ-032 ADDR_W=2, KEY_BYTES=1, key=8'h00, start pulse -> memory [0,2,3,1]; fin_strobe 28 edges after start; i=j swaps at i=0 and i=1 leave values unchanged.
REQ-033 Defaults, key=24'h000249 -> all 256 bytes match the software RC4 KSA model; fin_strobe high exactly one cycle, 1792 edges after start.
REQ-034 Defaults, pulse start 100 cycles into a run -> no restart; fin_strobe still at edge 1792; result matches model.
REQ-035 rst=0 during WRI of i=50 -> next cycle all outputs 0 and task_on=0; restart with key=24'h000249 -> model-exact result.
REQ-036 KEY_BYTES=5, key=40'h0102030405 -> matches model; key byte index wraps every 5.
REQ-037 Every cycle -> wr_en only in INIT/WRI/WRJ, task_on=~IDLE, fin_strobe never high two consecutive cycles.
